// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
//   Conditions two asynchronous raw pins into clean, glitch-free levels for the
//   downstream AND-chain. Each channel synchronises its pin through a short
//   flop chain and then only accepts a new level once it has persisted for
//   DEB_CNT consecutive synchronised cycles.
//
// Parameters
//   SYNC_STAGES : synchroniser depth per channel (2..4)
//   DEB_CNT     : consecutive synchronised cycles a new level must persist
//                 before it is accepted (1..255)
//
// Ports
//   clk      : single clock, all state updates on its rising edge
//   rst_n    : asynchronous active-low reset
//   raw_in1  : raw asynchronous level, channel 1
//   raw_in2  : raw asynchronous level, channel 2
//   in1      : debounced channel 1 level (registered)
//   in2      : debounced channel 2 level (registered)
//   in1_chg  : one-cycle pulse in the cycle in1 takes a new value
//   in2_chg  : one-cycle pulse in the cycle in2 takes a new value
// -----------------------------------------------------------------------------

// One debounce channel: synchroniser, persistence counter and a two-state FSM.
module input_debounce_channel #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic chg
);

    // Counter wide enough to hold DEB_CNT, never narrower than one bit.
    localparam int CW = ($clog2(DEB_CNT + 1) > 1) ? $clog2(DEB_CNT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   chg_q, chg_d;

    // Last synchroniser stage is the only point where the pin is safe to use.
    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            chg_q   <= chg_d;
        end
    end

    // NOTE: every combinational output gets a default before any branch, so
    // no path through the block leaves a signal unassigned (no latches).
    always_comb begin
        state_d = STABLE;
        cnt_d   = '0;
        level_d = level_q;
        chg_d   = 1'b0;

        case (state_q)
            STABLE: begin
                // Counter is zero here, so DEB_CNT == 1 accepts straight away.
                if (s != level_q) begin
                    if (cnt_q == CNT_LAST) begin
                        level_d = s;
                        chg_d   = 1'b1;
                    end else begin
                        state_d = PENDING;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            PENDING: begin
                // A return to the accepted level drops any partial count.
                if (s != level_q) begin
                    if (cnt_q == CNT_LAST) begin
                        level_d = s;
                        chg_d   = 1'b1;
                    end else begin
                        state_d = PENDING;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = STABLE;
            end
        endcase
    end

    assign level = level_q;
    assign chg   = chg_q;

endmodule

module input_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in1,
    input  logic raw_in2,
    output logic in1,
    output logic in2,
    output logic in1_chg,
    output logic in2_chg
);

    // Two identical channels with no shared state; both may accept together.
    input_debounce_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CNT     (DEB_CNT)
    ) u_ch1 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_in1),
        .level (in1),
        .chg   (in1_chg)
    );

    input_debounce_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CNT     (DEB_CNT)
    ) u_ch2 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_in2),
        .level (in2),
        .chg   (in2_chg)
    );

endmodule

// File: tb/tb_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_input_debounce
//   Two instances: A at default parameters, B with SYNC_STAGES=3, DEB_CNT=1.
//   Channel index: 0 = A.in1, 1 = A.in2, 2 = B.in1, 3 = B.in2.
//   A reference model sees the raw level at every edge, delays it by the
//   synchroniser depth and accepts a new level once the last DEB_CNT
//   synchronised samples all differ from the current level. Accepted changes
//   are queued as (edge, value); a monitor pops them when a chg pulse appears.
// -----------------------------------------------------------------------------
module tb_input_debounce;

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    localparam int SYNC_OF [4] = '{2, 2, 3, 3};
    localparam int DEB_OF  [4] = '{4, 4, 1, 1};

    logic       clk;
    logic       rst_n;
    logic [3:0] raw_v;
    logic       in1_a, in2_a, in1_chg_a, in2_chg_a;
    logic       in1_b, in2_b, in1_chg_b, in2_chg_b;
    logic [3:0] dut_lvl;
    logic [3:0] dut_chg;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic mon_en   = 1'b0;
    int   chg_cnt [4];

    // Reference model state
    logic raw_hist [4][8];
    logic s_hist   [4][8];
    logic mdl_lvl  [4];
    ev_t  exp_q    [4][$];

    input_debounce u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_in1 (raw_v[0]),
        .raw_in2 (raw_v[1]),
        .in1     (in1_a),
        .in2     (in2_a),
        .in1_chg (in1_chg_a),
        .in2_chg (in2_chg_a)
    );

    input_debounce #(
        .SYNC_STAGES (3),
        .DEB_CNT     (1)
    ) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_in1 (raw_v[2]),
        .raw_in2 (raw_v[3]),
        .in1     (in1_b),
        .in2     (in2_b),
        .in1_chg (in1_chg_b),
        .in2_chg (in2_chg_b)
    );

    assign dut_lvl = {in2_b, in1_b, in2_a, in1_a};
    assign dut_chg = {in2_chg_b, in1_chg_b, in2_chg_a, in1_chg_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 8; j++) begin
                raw_hist[c][j] = 1'b0;
                s_hist[c][j]   = 1'b0;
            end
            mdl_lvl[c] = 1'b0;
            exp_q[c].delete();
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 4; c++) begin
            logic s_now;
            logic all_diff;
            // Synchronised value at this edge is the raw level SYNC edges ago.
            s_now = raw_hist[c][SYNC_OF[c]-1];
            for (int j = 7; j > 0; j--) s_hist[c][j] = s_hist[c][j-1];
            s_hist[c][0] = s_now;
            all_diff = 1'b1;
            for (int j = 0; j < DEB_OF[c]; j++)
                if (s_hist[c][j] == mdl_lvl[c]) all_diff = 1'b0;
            if (all_diff) begin
                ev_t ev;
                mdl_lvl[c] = ~mdl_lvl[c];
                ev.cyc = cyc;
                ev.val = mdl_lvl[c];
                exp_q[c].push_back(ev);
            end
            for (int j = 7; j > 0; j--) raw_hist[c][j] = raw_hist[c][j-1];
            raw_hist[c][0] = raw_v[c];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                if (clk) cyc++;
                model_reset();
            end else begin
                cyc++;
                model_edge();
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        for (int c = 0; c < 4; c++) chg_cnt[c] = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (exp_q[c].size() > 0 && exp_q[c][0].cyc < cyc) begin
                    check($sformatf("missed_chg_ch%0d", c), 32'd0, 32'd1);
                    void'(exp_q[c].pop_front());
                end
                check($sformatf("level_ch%0d", c), 32'(dut_lvl[c]), 32'(mdl_lvl[c]));
                if (dut_chg[c]) begin
                    chg_cnt[c]++;
                    if (exp_q[c].size() == 0) begin
                        check($sformatf("spurious_chg_ch%0d", c), 32'd1, 32'd0);
                    end else begin
                        ev_t ev;
                        ev = exp_q[c].pop_front();
                        check($sformatf("chg_edge_ch%0d", c), 32'(cyc), 32'(ev.cyc));
                        check($sformatf("chg_value_ch%0d", c), 32'(dut_lvl[c]), 32'(ev.val));
                    end
                end
            end
        end
    end

    // Count edges (sampled 1 time unit after each edge) until a level appears.
    task automatic wait_level(input int c, input logic v, input int max, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (dut_lvl[c] !== v && edges <= max);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int e;
        int base;
        int hold [4];

        rst_n = 1'b0;
        raw_v = 4'b0000;
        #12;
        mon_en = 1'b1;
        check("reset_levels", 32'(dut_lvl), 32'd0);
        check("reset_chg", 32'(dut_chg), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Clean 0->1 on A.in1: accepted on the 6th edge, pulse lasts one cycle.
        #2 raw_v[0] = 1'b1;
        wait_level(0, 1'b1, 20, e);
        check("latency_in1", 32'(e), 32'd6);
        check("chg_at_accept_in1", 32'(dut_chg[0]), 32'd1);
        @(posedge clk); #1;
        check("chg_cleared_in1", 32'(dut_chg[0]), 32'd0);
        check("level_held_in1", 32'(dut_lvl[0]), 32'd1);

        // Three-cycle glitch on A.in2 must be rejected.
        @(posedge clk); #2;
        base = chg_cnt[1];
        raw_v[1] = 1'b1;
        repeat (3) @(posedge clk);
        #2 raw_v[1] = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk); #1;
        check("glitch_level_in2", 32'(dut_lvl[1]), 32'd0);
        check("glitch_no_chg_in2", 32'(chg_cnt[1] - base), 32'd0);

        // High 3, low 1, high held: count restarts from the final rise.
        @(posedge clk); #2 raw_v[1] = 1'b1;
        repeat (3) @(posedge clk);
        #2 raw_v[1] = 1'b0;
        @(posedge clk);
        #2 raw_v[1] = 1'b1;
        wait_level(1, 1'b1, 20, e);
        check("restart_latency_in2", 32'(e), 32'd6);

        // Both channels rise together: pulses coincide.
        @(posedge clk); #2 raw_v[1:0] = 2'b00;
        repeat (10) @(posedge clk);
        #1 check("both_low", 32'(dut_lvl[1:0]), 32'd0);
        @(posedge clk); #2 raw_v[1:0] = 2'b11;
        wait_level(0, 1'b1, 20, e);
        check("simul_latency", 32'(e), 32'd6);
        check("simul_chg", 32'(dut_chg[1:0]), 32'd3);

        // Reset in the middle of a pending change on A.in1.
        @(posedge clk); #2 raw_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2 raw_v[0] = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midcount_reset_levels", 32'(dut_lvl), 32'd0);
        check("midcount_reset_chg", 32'(dut_chg), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_level(0, 1'b1, 20, e);
        check("post_reset_latency_in1", 32'(e), 32'd6);
        check("post_reset_chg_in1", 32'(dut_chg[0]), 32'd1);

        // B.in2 (DEB_CNT=1, SYNC_STAGES=3): one-cycle pulse passes through.
        repeat (3) @(posedge clk);
        #2;
        base = chg_cnt[3];
        raw_v[3] = 1'b1;
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
            if (e == 1) raw_v[3] = 1'b0;
        end while (dut_lvl[3] !== 1'b1 && e <= 10);
        check("pulse_latency_b_in2", 32'(e), 32'd4);
        check("pulse_rise_chg_b_in2", 32'(dut_chg[3]), 32'd1);
        @(posedge clk); #1;
        check("pulse_width_b_in2", 32'(dut_lvl[3]), 32'd0);
        check("pulse_fall_chg_b_in2", 32'(dut_chg[3]), 32'd1);
        @(negedge clk); #1;
        check("pulse_chg_count_b_in2", 32'(chg_cnt[3] - base), 32'd2);

        // Randomised levels with random hold times and occasional resets.
        for (int c = 0; c < 4; c++) hold[c] = 1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #2;
            for (int c = 0; c < 4; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin
                    raw_v[c] = ~raw_v[c];
                    hold[c]  = $urandom_range(1, 9);
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("random_reset_levels", 32'(dut_lvl), 32'd0);
                check("random_reset_chg", 32'(dut_chg), 32'd0);
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
            end
        end

        // Quiet tail so every queued change is either seen or reported.
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        for (int c = 0; c < 4; c++)
            check($sformatf("pending_empty_ch%0d", c), 32'(exp_q[c].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Role: upstream stage of the top-level AND-chain design. Conditions asynchronous raw pins into clean, glitch-free in1/in2 for the chain.

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth per channel; legal range 2..4.
REQ-002 SHALL have parameter DEB_CNT, default 4, meaning the consecutive synchronised cycles a new level must persist before acceptance; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port raw_in1, input, 1 bit: asynchronous raw level, channel 1.
REQ-006 SHALL have port raw_in2, input, 1 bit: asynchronous raw level, channel 2.
REQ-007 SHALL have port in1, output, 1 bit: debounced channel 1 level, driven from a flop.
REQ-008 SHALL have port in2, output, 1 bit: debounced channel 2 level, driven from a flop.
REQ-009 SHALL have port in1_chg, output, 1 bit: one-cycle pulse in the cycle in which in1 takes a new value.
REQ-010 SHALL have port in2_chg, output, 1 bit: one-cycle pulse in the cycle in which in2 takes a new value.

Function
REQ-011 Channels 1 and 2 SHALL be identical and fully independent; no shared state.
REQ-012 Each channel SHALL pass raw_inX through a chain of SYNC_STAGES flops; the last stage is the synchronised value sX.
REQ-013 Each channel SHALL hold a counter of width clog2(DEB_CNT+1), minimum 1 bit.
REQ-014 Each channel SHALL implement a two-state FSM:
- STABLE: sX == inX, counter 0.
- PENDING: sX != inX, counter counting.
REQ-015 On a rising edge with sX == inX, the channel SHALL go to STABLE and clear the counter, discarding any partial count (glitch rejection).
REQ-016 On a rising edge with sX != inX and counter < DEB_CNT-1, the channel SHALL increment the counter and be in PENDING.
REQ-017 On a rising edge with sX != inX and counter == DEB_CNT-1, the channel SHALL:
- load inX <= sX;
- clear the counter;
- set inX_chg to 1;
- return to STABLE.
REQ-018 inX_chg SHALL be 1 for exactly one cycle per accepted change and 0 otherwise.
REQ-019 With DEB_CNT == 1, any single-cycle mismatch SHALL be accepted at the next edge (synchroniser only, no filtering).
REQ-020 Latency from a clean raw edge (set up before edge 0) to the inX change SHALL be exactly SYNC_STAGES+DEB_CNT rising edges; 6 edges at defaults.
REQ-021 A mismatch lasting fewer than DEB_CNT consecutive synchronised cycles SHALL leave inX unchanged and inX_chg at 0.
REQ-022 The counter SHALL never exceed DEB_CNT-1 and SHALL never wrap.
REQ-023 Simultaneous acceptance on both channels SHALL be allowed: in1_chg and in2_chg may pulse in the same cycle.

Reset
REQ-024 While rst_n is 0, the following SHALL be 0 immediately, independent of clk: all synchroniser flops, counters, in1, in2, in1_chg, in2_chg; FSM in STABLE.
REQ-025 Assertion of rst_n mid-count SHALL discard the pending change; no inX_chg pulse SHALL follow reset release.
REQ-026 After rst_n deasserts, a raw level of 1 SHALL be accepted after SYNC_STAGES+DEB_CNT edges, as a normal change from 0 with a chg pulse.

Verification
REQ-027 Defaults; raw_in1 0->1 held -> in1=1 and in1_chg=1 at edge 6 after the change; in1_chg=0 at edge 7.
REQ-028 Defaults; raw_in1 high for 3 cycles, then low -> in1 stays 0, in1_chg never pulses.
REQ-029 Defaults; raw_in1 high 3 cycles, low 1 cycle, high held -> counter restarts; in1=1 only 6 edges after the final rise.
REQ-030 Defaults; raw_in1 and raw_in2 rise together -> in1_chg and in2_chg pulse in the same cycle.
REQ-031 rst_n pulsed low at edge 4 of a pending 0->1 change, raw held high -> outputs 0 immediately; in1=1 exactly 6 edges after rst_n release.
REQ-032 DEB_CNT=1, SYNC_STAGES=3; single-cycle raw_in2 pulse aligned to clk -> in2 high for 1 cycle starting 4 edges later, with in2_chg pulses on both the rise and the fall.
